sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences the team's dual-port FIFO memory (registered write port, combinational read port). It owns the read/write pointers, generates the memory's write enable and both addresses, and produces registered full/empty/occupancy/watermark status. Read data comes straight from the memory at raddr and is valid whenever empty is low (first-word-fall-through).

Parameters:
ADDRSIZE, 4, memory address bits; DEPTH = 2**ADDRSIZE entries
AF_LEVEL, 14, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
push  input  1  write request; data on memory wdata this cycle
pop  input  1  read request; consumes the word currently at raddr
wclken  output  1  memory write enable, high only for accepted pushes
waddr  output  ADDRSIZE  memory write address = wptr[ADDRSIZE-1:0]
raddr  output  ADDRSIZE  memory read address = rptr[ADDRSIZE-1:0]
full  output  1  registered, count == DEPTH
empty  output  1  registered, count == 0
count  output  ADDRSIZE+1  registered occupancy 0..DEPTH
almost_full  output  1  registered watermark flag
almost_empty  output  1  registered watermark flag
overflow  output  1  sticky error flag (FIFO_ERRFLAG_EN only, else tied 0)
underflow  output  1  sticky error flag (FIFO_ERRFLAG_EN only, else tied 0)
clr_err  input  1  synchronous clear of overflow/underflow (ignored without macro)

Behaviour:
- Reset (rst_n low, asynchronous): wptr=rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=underflow=0. wclken is combinational and therefore 0 whenever push=0.
- Pointers are ADDRSIZE+1 bits; the MSB is the wrap bit; increment modulo 2**(ADDRSIZE+1). Low bits wrap from DEPTH-1 to 0.
- Push accepted (push_ok) = push & (!full | pop). Pop accepted (pop_ok) = pop & !empty.
- wclken = push_ok (combinational, same cycle). On the edge, push_ok -> wptr+1 and pop_ok -> rptr+1.
- count_next = count + push_ok - pop_ok. full, empty, almost_* and count are all registered from count_next, so they change on the same edge that moves the pointers (1-cycle latency from request to flag).
- Invariant: count == wptr - rptr (mod 2**(ADDRSIZE+1)); full iff pointer low bits are equal and MSBs differ.
- Push+pop while empty: push accepted, pop ignored; count becomes 1, empty drops next cycle.
- Push+pop while full: both accepted; write lands at old raddr location after the read of the current data; count stays DEPTH, full stays 1.
- Push+pop otherwise: both accepted; count unchanged.
- Push while full without pop: dropped; wclken=0; pointers unchanged.
- Pop while empty: ignored; pointers unchanged.
- Reset asserted mid-operation: state clears immediately regardless of clk; memory contents are not cleared but are unreachable because empty=1.

Optional Feature:
FIFO_ERRFLAG_EN: when defined, overflow sets on any cycle with push & full & !pop, and underflow sets on any cycle with pop & empty. Both hold until clr_err=1 at a clock edge (clr_err has priority over a same-cycle set) or until reset. When not defined, overflow=underflow=0 constantly, clr_err is unused, and no error registers are built.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, almost_empty=1, waddr=raddr=0, wclken=0.
- 16 consecutive pushes (ADDRSIZE=4) -> count 1..16, almost_full rises at count=14, full=1 after 16th edge; 17th push -> wclken=0, count stays 16, overflow=1 (macro on) or 0 (macro off).
- From full, 16 pops -> data read in push order, count decrements to 0, empty=1 after last edge; extra pop -> rptr unchanged, underflow=1 (macro on).
- Push+pop every cycle for 40 cycles starting at count=3 -> count stays 3, waddr/raddr wrap 15->0 at least twice, data order preserved.
- Simultaneous push+pop when empty -> count=1, empty=0 next cycle; when full -> count=16, written word read back 16 pops later.
- Assert rst_n low between clock edges with count=9 -> outputs reach reset values immediately, without waiting for clk; clr_err pulse with simultaneous overflow condition -> overflow reads 0.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock first-word-fall-through FIFO controller for an external dual-port memory.
// Build with FIFO_ERRFLAG_EN defined to get sticky overflow/underflow flags; otherwise both are tied low.
module sync_fifo_ctrl #(
    parameter int unsigned ADDRSIZE = 4,
    parameter int unsigned AF_LEVEL = 14,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic                clr_err,
    output logic                wclken,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                full,
    output logic                empty,
    output logic [ADDRSIZE:0]   count,
    output logic                almost_full,
    output logic                almost_empty,
    output logic                overflow,
    output logic                underflow
);

    localparam int unsigned PW    = ADDRSIZE + 1;
    localparam int unsigned DEPTH = 1 << ADDRSIZE;

    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_almost_full;
    logic          r_almost_empty;

    logic          w_push_ok;
    logic          w_pop_ok;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;
    logic [PW-1:0] w_count_nxt;

    // A push into a full FIFO is allowed when the same cycle's pop frees the slot.
    always_comb begin
        w_push_ok   = push & (~r_full | pop);
        w_pop_ok    = pop & ~r_empty;
        w_wptr_nxt  = r_wptr + PW'(w_push_ok);
        w_rptr_nxt  = r_rptr + PW'(w_pop_ok);
        w_count_nxt = r_count + PW'(w_push_ok) - PW'(w_pop_ok);
    end

    // Pointers and all status flags move together on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_wptr         <= w_wptr_nxt;
            r_rptr         <= w_rptr_nxt;
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == PW'(DEPTH));
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= PW'(AF_LEVEL));
            r_almost_empty <= (w_count_nxt <= PW'(AE_LEVEL));
        end
    end

    assign wclken       = w_push_ok;
    assign waddr        = r_wptr[ADDRSIZE-1:0];
    assign raddr        = r_rptr[ADDRSIZE-1:0];
    assign full         = r_full;
    assign empty        = r_empty;
    assign count        = r_count;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;

`ifdef FIFO_ERRFLAG_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky error flags; a clear wins over a set in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr_err) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (push & r_full & ~pop) begin
                r_overflow <= 1'b1;
            end
            if (pop & r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    logic w_unused_clr_err;

    assign w_unused_clr_err = clr_err;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

    // Structural invariants tying occupancy to the pointer pair.
    a_count_ptr: assert property (@(posedge clk) disable iff (!rst_n)
        r_count == PW'(r_wptr - r_rptr));

    a_full_ptr: assert property (@(posedge clk) disable iff (!rst_n)
        r_full == ((r_wptr[ADDRSIZE-1:0] == r_rptr[ADDRSIZE-1:0]) &&
                   (r_wptr[ADDRSIZE] != r_rptr[ADDRSIZE])));

    a_empty_ptr: assert property (@(posedge clk) disable iff (!rst_n)
        r_empty == (r_wptr == r_rptr));

    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= PW'(DEPTH));

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomized scoreboard bench for sync_fifo_ctrl with a behavioural memory and occupancy model.
// Expectations for overflow/underflow follow whether FIFO_ERRFLAG_EN is defined.
module tb_sync_fifo_ctrl;

    localparam int unsigned ADDRSIZE = 4;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned AF_LEVEL = 14;
    localparam int unsigned AE_LEVEL = 2;
    localparam int unsigned DW       = 8;

    logic                clk;
    logic                rst_n;
    logic                push;
    logic                pop;
    logic                clr_err;
    logic                wclken;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE-1:0] raddr;
    logic                full;
    logic                empty;
    logic [ADDRSIZE:0]   count;
    logic                almost_full;
    logic                almost_empty;
    logic                overflow;
    logic                underflow;

    logic [DW-1:0]       wdata;
    logic [DW-1:0]       rdata;
    logic [DW-1:0]       mem [DEPTH];

    int                  n_checks;
    int                  n_fail;
    int                  m_wr;
    int                  m_rd;
    bit                  m_ovf;
    bit                  m_unf;
    logic [DW-1:0]       exp_q [$];

    sync_fifo_ctrl #(
        .ADDRSIZE (ADDRSIZE),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .pop          (pop),
        .clr_err      (clr_err),
        .wclken       (wclken),
        .waddr        (waddr),
        .raddr        (raddr),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dual-port memory: registered write, combinational read.
    always @(posedge clk) begin
        if (wclken) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];

    task automatic chk(input string tag, input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d expected %0d at %0t", tag, name, act, exp, $time);
        end
    endtask

    task automatic check_status(input string tag);
        int c;
        c = m_wr - m_rd;
        chk(tag, "count", int'(count), c);
        chk(tag, "full", int'(full), int'(c == int'(DEPTH)));
        chk(tag, "empty", int'(empty), int'(c == 0));
        chk(tag, "almost_full", int'(almost_full), int'(c >= int'(AF_LEVEL)));
        chk(tag, "almost_empty", int'(almost_empty), int'(c <= int'(AE_LEVEL)));
        chk(tag, "waddr", int'(waddr), m_wr % int'(DEPTH));
        chk(tag, "raddr", int'(raddr), m_rd % int'(DEPTH));
`ifdef FIFO_ERRFLAG_EN
        chk(tag, "overflow", int'(overflow), int'(m_ovf));
        chk(tag, "underflow", int'(underflow), int'(m_unf));
`else
        chk(tag, "overflow", int'(overflow), 0);
        chk(tag, "underflow", int'(underflow), 0);
`endif
    endtask

    // One clock of stimulus, starting and ending just after a falling edge.
    task automatic step(input bit p, input bit q, input bit clr, input string tag);
        int c;
        bit pok;
        bit qok;
        c       = m_wr - m_rd;
        push    = p;
        pop     = q;
        clr_err = clr;
        wdata   = DW'($urandom);
        pok     = p && (c < int'(DEPTH) || q);
        qok     = q && (c > 0);
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (p && c == int'(DEPTH) && !q) m_ovf = 1'b1;
            if (q && c == 0) m_unf = 1'b1;
        end
        #1;
        chk(tag, "wclken", int'(wclken), int'(pok));
        if (pok) begin
            exp_q.push_back(wdata);
            m_wr++;
        end
        if (qok) m_rd++;
        @(negedge clk);
        check_status(tag);
    endtask

    // Reset dropped between edges must clear everything without a clock.
    task automatic async_reset(input string tag);
        #2;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
        rst_n   = 1'b0;
        #1;
        m_wr  = 0;
        m_rd  = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        exp_q.delete();
        check_status(tag);
        chk(tag, "wclken", int'(wclken), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_status({tag, "_rel"});
    endtask

    // Monitor: every accepted read must return the oldest outstanding written word.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && pop && !empty) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL mon/rdata: got %0d expected no read (scoreboard empty) at %0t",
                             rdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon", "rdata", int'(rdata), int'(e));
                end
            end
        end
    end

    initial begin
        int pb;
        bit p;
        bit q;
        bit clr;
        n_checks = 0;
        n_fail   = 0;
        m_wr     = 0;
        m_rd     = 0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        clr_err  = 1'b0;
        wdata    = '0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_status("reset");
        chk("reset", "wclken", int'(wclken), 0);
        step(1'b0, 1'b0, 1'b0, "idle");

        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 1'b0, "fill");
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b0, "drain");
        step(1'b0, 1'b0, 1'b1, "clr");

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, "pre_stream");
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, "stream");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, "post_stream");

        step(1'b1, 1'b1, 1'b0, "pp_empty");
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0, "fill2");
        step(1'b1, 1'b1, 1'b0, "pp_full");
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, "drain2");

        for (int i = 0; i < 512; i++) begin
            pb  = ((i / 64) % 2 == 0) ? 70 : 30;
            p   = ($urandom_range(0, 99) < pb);
            q   = ($urandom_range(0, 99) < (100 - pb));
            clr = ($urandom_range(0, 15) == 0);
            step(p, q, clr, "rand");
        end

        for (int i = 0; i < int'(DEPTH) && (m_wr - m_rd) < int'(DEPTH); i++)
            step(1'b1, 1'b0, 1'b0, "refill");
        step(1'b1, 1'b0, 1'b0, "ovf_set");
        step(1'b1, 1'b0, 1'b1, "ovf_clr");

        for (int i = 0; i < int'(DEPTH) && (m_wr - m_rd) > 9; i++)
            step(1'b0, 1'b1, 1'b0, "to9");
        chk("to9", "model_count", m_wr - m_rd, 9);
        async_reset("async_rst");
        step(1'b1, 1'b0, 1'b0, "post_rst");
        step(1'b0, 1'b1, 1'b0, "post_rst_pop");

        for (int i = 0; i <= int'(DEPTH) && (m_wr - m_rd) > 0; i++)
            step(1'b0, 1'b1, 1'b0, "final");
        step(1'b0, 1'b0, 1'b0, "final_idle");
        chk("end", "sb_left", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
